vending_buyer: RTL and testbench
================================

Name: vending_buyer

Overview:
- Protocol initiator that drives the customer side of the vending machine controller: issues the product request, inserts coins, requests change and collects the product.
- Accepts one purchase command (product code, payment coin denomination) and runs the whole transaction autonomously.
- Reports coins paid, change received and no-change/error status.
- Used as a traffic generator in system benches and as the front-panel sequencer in the top level.

Parameters:
WIDTH_OF_MONEY, 16, width of all money accumulators; must be at least 10
TIMEOUT_CYCLES, 64, number of cycles with no machine event before a transaction is aborted

Ports:
clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_cmd_valid  input  1  purchase command valid
i_cmd_product  input  2  product code to buy
i_cmd_coin  input  3  currency code used for every coin inserted
o_cmd_ready  output  1  high in IDLE; command is accepted when i_cmd_valid && o_cmd_ready
o_product_code  output  2  to machine product code
o_product_strobe  output  1  to machine product request pulse
o_currency_code  output  3  to machine currency code
o_currency_strobe  output  1  to machine coin strobe / change-request level
i_busy  input  1  from machine
i_ready_to_receive  input  1  from machine
i_change  input  3  from machine, currency code of a returned coin
i_change_strobe  input  1  from machine
i_no_change  input  1  from machine
i_product  input  2  from machine
i_give_strobe  input  1  from machine
o_done  output  1  one-cycle pulse at transaction end
o_error  output  1  valid with o_done; timeout abort
o_no_change  output  1  valid with o_done; machine reported no change
o_product_ok  output  1  valid with o_done; i_product == requested code
o_paid  output  WIDTH_OF_MONEY  valid with o_done; total value inserted
o_change_total  output  WIDTH_OF_MONEY  valid with o_done; total change value received
o_change_count  output  8  valid with o_done; number of change coins received, saturating at 255

Behaviour:
- All outputs are registered. The one exception is o_cmd_ready, which decodes state.
- Reset: the state machine goes to IDLE. Every output resets to 0, except o_cmd_ready, which is 1 because it decodes IDLE. All accumulators and the timeout counter clear. Reset mid-transaction drops both strobes immediately.
- Tables, indexed by code:
  - Prices: 0=150, 1=300, 2=200, 3=100.
  - Coin values: 0=1, 1=5, 2=10, 3=25, 4=50, 5=100, 6=200, 7=500.
- IDLE:
  - On command accept, latch product and coin; clear paid, change_total, change_count and the no_change flag.
  - Drive o_product_code and o_product_strobe=1 for exactly one cycle; next state is WAIT_READY.
  - i_cmd_valid is ignored in every other state.
- WAIT_READY:
  - When i_ready_to_receive=1, assert o_currency_strobe=1 with o_currency_code=coin for exactly one cycle.
  - In that same edge, add the coin value to paid; next state is INSERT.
- INSERT (one cycle, strobe low again):
  - If paid < price, next state is WAIT_READY. The machine's RECEIVED cycle guarantees ready is low when it is next sampled.
  - Otherwise, next state is COLLECT.
- COLLECT:
  - Hold o_currency_strobe=1 continuously; this is the change-request level.
  - On each i_change_strobe: change_total += value(i_change), and change_count += 1.
  - On i_no_change: set the no_change flag.
  - On i_give_strobe: capture o_product_ok, drop the strobe, next state is WAIT_IDLE.
  - Exact payment reaches give_strobe without any change strobes. This is legal.
  - i_change_strobe and i_give_strobe in the same cycle: count the change and finish.
- WAIT_IDLE: when i_busy=0, pulse o_done with result outputs; next state is IDLE. Result outputs hold until the next command accept.
- Timeout:
  - The counter runs in every non-IDLE state.
  - It clears on state change or any of i_change_strobe, i_no_change, i_give_strobe.
  - On reaching TIMEOUT_CYCLES: drop both strobes, pulse o_done with o_error=1 and the partial paid/change values, then go to IDLE.
- Width rules:
  - paid and change_total wrap modulo 2^WIDTH_OF_MONEY. This cannot wrap with defaults.
  - change_count saturates at 255.

Test Plan:
- Product 3, coin 5 (100): one currency strobe -> o_done with o_paid=100, o_change_total=0, o_change_count=0, o_product_ok=1, o_error=0.
- Product 0, coin 4 (50): exactly three one-cycle currency strobes, each issued only while ready=1 -> o_paid=150, o_change_total=0.
- Product 3, coin 7 (500) against a machine with default stock 10 -> change codes 6, 6; o_change_total=400, o_change_count=2, o_no_change=0.
- Product 3, coin 7 against a machine with stock of codes 6 and 5 forced to 0 -> machine returns 50-unit coins (code 4) until exhausted, then o_no_change=1 with o_change_total equal to the coins actually returned.
- Responder model never asserts ready -> product strobe, then exactly TIMEOUT_CYCLES=64 cycles later o_done with o_error=1 and both strobes low; i_cmd_valid held high mid-transaction is ignored.
- Reset asserted during COLLECT -> strobes fall asynchronously, o_cmd_ready=1 after release, and a following 100/coin-5 purchase completes normally.

Source files
------------

// File: rtl/vending_buyer_if.sv
// Customer-side link between the buyer sequencer and the vending machine controller.
// Signal names keep the buyer's point of view (o_* driven by buyer, i_* driven by machine).
interface vending_buyer_if;
    logic [1:0] o_product_code;
    logic       o_product_strobe;
    logic [2:0] o_currency_code;
    logic       o_currency_strobe;
    logic       i_busy;
    logic       i_ready_to_receive;
    logic [2:0] i_change;
    logic       i_change_strobe;
    logic       i_no_change;
    logic [1:0] i_product;
    logic       i_give_strobe;

    modport master (
        output o_product_code, o_product_strobe, o_currency_code, o_currency_strobe,
        input  i_busy, i_ready_to_receive, i_change, i_change_strobe, i_no_change,
               i_product, i_give_strobe
    );

    modport slave (
        input  o_product_code, o_product_strobe, o_currency_code, o_currency_strobe,
        output i_busy, i_ready_to_receive, i_change, i_change_strobe, i_no_change,
               i_product, i_give_strobe
    );
endinterface

// File: rtl/vending_buyer.sv
// Autonomous purchase sequencer: requests a product, feeds coins until the price is met,
// collects change and the product, and reports the transaction result.
module vending_buyer #(
    parameter int WIDTH_OF_MONEY = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic                      i_cmd_valid,
    input  logic [1:0]                i_cmd_product,
    input  logic [2:0]                i_cmd_coin,
    output logic                      o_cmd_ready,
    vending_buyer_if.master           mach,
    output logic                      o_done,
    output logic                      o_error,
    output logic                      o_no_change,
    output logic                      o_product_ok,
    output logic [WIDTH_OF_MONEY-1:0] o_paid,
    output logic [WIDTH_OF_MONEY-1:0] o_change_total,
    output logic [7:0]                o_change_count
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    typedef logic [WIDTH_OF_MONEY-1:0] money_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_INSERT,
        S_COLLECT,
        S_WAIT_IDLE
    } state_t;

    function automatic money_t price(input logic [1:0] code);
        case (code)
            2'd0:    price = money_t'(150);
            2'd1:    price = money_t'(300);
            2'd2:    price = money_t'(200);
            default: price = money_t'(100);
        endcase
    endfunction

    function automatic money_t coin_value(input logic [2:0] code);
        case (code)
            3'd0:    coin_value = money_t'(1);
            3'd1:    coin_value = money_t'(5);
            3'd2:    coin_value = money_t'(10);
            3'd3:    coin_value = money_t'(25);
            3'd4:    coin_value = money_t'(50);
            3'd5:    coin_value = money_t'(100);
            3'd6:    coin_value = money_t'(200);
            default: coin_value = money_t'(500);
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [1:0] prod_q, prod_d;
    logic [2:0] coin_q, coin_d;
    logic       prod_strobe_q, prod_strobe_d;
    logic       cur_strobe_q, cur_strobe_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       no_change_q, no_change_d;
    logic       product_ok_q, product_ok_d;
    money_t     paid_q, paid_d;
    money_t     chg_total_q, chg_total_d;
    logic [7:0] chg_count_q, chg_count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       machine_event;

    assign machine_event = mach.i_change_strobe | mach.i_no_change | mach.i_give_strobe;

    always_comb begin
        state_d       = state_q;
        prod_d        = prod_q;
        coin_d        = coin_q;
        prod_strobe_d = 1'b0;
        cur_strobe_d  = 1'b0;
        done_d        = 1'b0;
        error_d       = error_q;
        no_change_d   = no_change_q;
        product_ok_d  = product_ok_q;
        paid_d        = paid_q;
        chg_total_d   = chg_total_q;
        chg_count_d   = chg_count_q;
        cnt_d         = '0;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    prod_d        = i_cmd_product;
                    coin_d        = i_cmd_coin;
                    paid_d        = '0;
                    chg_total_d   = '0;
                    chg_count_d   = '0;
                    no_change_d   = 1'b0;
                    error_d       = 1'b0;
                    product_ok_d  = 1'b0;
                    prod_strobe_d = 1'b1;
                    state_d       = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (mach.i_ready_to_receive) begin
                    cur_strobe_d = 1'b1;
                    paid_d       = paid_q + coin_value(coin_q);
                    state_d      = S_INSERT;
                end
            end
            S_INSERT: begin
                if (paid_q < price(prod_q)) begin
                    state_d = S_WAIT_READY;
                end else begin
                    cur_strobe_d = 1'b1;
                    state_d      = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Strobe held high here is the change-request level seen by the machine.
                cur_strobe_d = 1'b1;
                if (mach.i_change_strobe) begin
                    chg_total_d = chg_total_q + coin_value(mach.i_change);
                    if (chg_count_q != 8'hFF) begin
                        chg_count_d = chg_count_q + 8'd1;
                    end
                end
                if (mach.i_no_change) begin
                    no_change_d = 1'b1;
                end
                if (mach.i_give_strobe) begin
                    product_ok_d = (mach.i_product == prod_q);
                    cur_strobe_d = 1'b0;
                    state_d      = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!mach.i_busy) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Silence watchdog: a normal transition or machine activity restarts it.
        if (state_q != S_IDLE && state_d == state_q && !machine_event) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d       = S_IDLE;
                prod_strobe_d = 1'b0;
                cur_strobe_d  = 1'b0;
                done_d        = 1'b1;
                error_d       = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            prod_q        <= '0;
            coin_q        <= '0;
            prod_strobe_q <= 1'b0;
            cur_strobe_q  <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            no_change_q   <= 1'b0;
            product_ok_q  <= 1'b0;
            paid_q        <= '0;
            chg_total_q   <= '0;
            chg_count_q   <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            prod_q        <= prod_d;
            coin_q        <= coin_d;
            prod_strobe_q <= prod_strobe_d;
            cur_strobe_q  <= cur_strobe_d;
            done_q        <= done_d;
            error_q       <= error_d;
            no_change_q   <= no_change_d;
            product_ok_q  <= product_ok_d;
            paid_q        <= paid_d;
            chg_total_q   <= chg_total_d;
            chg_count_q   <= chg_count_d;
            cnt_q         <= cnt_d;
        end
    end

    assign o_cmd_ready            = (state_q == S_IDLE);
    assign mach.o_product_code    = prod_q;
    assign mach.o_product_strobe  = prod_strobe_q;
    assign mach.o_currency_code   = coin_q;
    assign mach.o_currency_strobe = cur_strobe_q;
    assign o_done                 = done_q;
    assign o_error                = error_q;
    assign o_no_change            = no_change_q;
    assign o_product_ok           = product_ok_q;
    assign o_paid                 = paid_q;
    assign o_change_total         = chg_total_q;
    assign o_change_count         = chg_count_q;
endmodule

// File: tb/tb_vending_buyer.sv
// Bench for vending_buyer: the bench plays the vending machine and scores each
// transaction against prices/coin values and the coins it actually handed out.
module tb_vending_buyer;
    localparam int W  = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_rst_n;
    logic          i_cmd_valid;
    logic [1:0]    i_cmd_product;
    logic [2:0]    i_cmd_coin;
    logic          o_cmd_ready;
    logic          o_done, o_error, o_no_change, o_product_ok;
    logic [W-1:0]  o_paid, o_change_total;
    logic [7:0]    o_change_count;

    vending_buyer_if mach ();

    vending_buyer #(.WIDTH_OF_MONEY(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_cmd_valid    (i_cmd_valid),
        .i_cmd_product  (i_cmd_product),
        .i_cmd_coin     (i_cmd_coin),
        .o_cmd_ready    (o_cmd_ready),
        .mach           (mach),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_no_change    (o_no_change),
        .o_product_ok   (o_product_ok),
        .o_paid         (o_paid),
        .o_change_total (o_change_total),
        .o_change_count (o_change_count)
    );

    int PRICE [4] = '{150, 300, 200, 100};
    int VAL   [8] = '{1, 5, 10, 25, 50, 100, 200, 500};

    int n_checks = 0;
    int n_pass   = 0;

    // Machine-side record of one transaction and DUT result snapshot at o_done.
    int stock_arr [8];
    int m_coins, m_sent_total, m_sent_n, m_nc;
    int d_paid, d_total, d_count, d_nc, d_pok, d_err;

    typedef struct {
        int          prod;
        int          coin;
        logic [31:0] stock;
        bit          bad;
        int          e_paid;
        int          e_total;
        int          e_count;
        int          e_nc;
        int          e_coins;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stock(input logic [31:0] nib);
        for (int k = 0; k < 8; k++) stock_arr[k] = int'(nib[4*k +: 4]);
    endtask

    task automatic purchase(input int prod, input int coin, input bit bad);
        int st [8];
        int paid_m, rem, c, n;
        bit ok, give_done;
        st = stock_arr;
        m_coins = 0; m_sent_total = 0; m_sent_n = 0; m_nc = 0;
        i_cmd_product = 2'(prod);
        i_cmd_coin    = 3'(coin);
        i_cmd_valid   = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        check("product_strobe", mach.o_product_strobe, 1);
        check("product_code", mach.o_product_code, prod);
        mach.i_busy = 1'b1;
        paid_m = 0;
        ok = 1'b1;
        while (ok && paid_m < PRICE[prod]) begin
            repeat ($urandom_range(0, 2)) tick();
            mach.i_ready_to_receive = 1'b1;
            n = 0;
            do begin tick(); n++; end while (!mach.o_currency_strobe && n < 20);
            mach.i_ready_to_receive = 1'b0;
            if (!mach.o_currency_strobe) begin
                check("coin_strobe_wait", 0, 1);
                ok = 1'b0;
            end else begin
                paid_m += VAL[mach.o_currency_code];
                m_coins++;
                tick();
                if (paid_m < PRICE[prod]) check("coin_strobe_one_cycle", mach.o_currency_strobe, 0);
            end
        end
        if (ok) begin
            check("collect_level", mach.o_currency_strobe, 1);
            rem = paid_m - PRICE[prod];
            give_done = 1'b0;
            while (rem > 0) begin
                c = -1;
                for (int k = 7; k >= 0; k--) if (c < 0 && st[k] > 0 && VAL[k] <= rem) c = k;
                repeat ($urandom_range(0, 2)) tick();
                if (c < 0) begin
                    mach.i_no_change = 1'b1;
                    m_nc = 1;
                    tick();
                    mach.i_no_change = 1'b0;
                    break;
                end
                st[c]--;
                rem -= VAL[c];
                m_sent_total += VAL[c];
                m_sent_n++;
                mach.i_change = 3'(c);
                mach.i_change_strobe = 1'b1;
                if (rem == 0 && $urandom_range(0, 1) == 1) begin
                    mach.i_product = 2'(bad ? (prod ^ 1) : prod);
                    mach.i_give_strobe = 1'b1;
                    give_done = 1'b1;
                end
                tick();
                mach.i_change_strobe = 1'b0;
                mach.i_give_strobe = 1'b0;
            end
            if (!give_done) begin
                repeat ($urandom_range(0, 2)) tick();
                mach.i_product = 2'(bad ? (prod ^ 1) : prod);
                mach.i_give_strobe = 1'b1;
                tick();
                mach.i_give_strobe = 1'b0;
            end
            check("strobe_drop_after_give", mach.o_currency_strobe, 0);
        end
        repeat ($urandom_range(0, 3)) tick();
        mach.i_busy = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!o_done && n < TO + 8);
        check("done_seen", o_done, 1);
        d_paid = int'(o_paid); d_total = int'(o_change_total); d_count = int'(o_change_count);
        d_nc = int'(o_no_change); d_pok = int'(o_product_ok); d_err = int'(o_error);
        tick();
        check("done_one_cycle", o_done, 0);
    endtask

    // Reference: payment is the smallest multiple of the coin value covering the
    // price; change results must equal what the machine actually returned.
    task automatic score(input string tag, input int prod, input int coin, input bit bad);
        int exp_paid;
        exp_paid = ((PRICE[prod] + VAL[coin] - 1) / VAL[coin]) * VAL[coin];
        check({tag, "_paid"}, d_paid, exp_paid);
        check({tag, "_coins"}, m_coins, exp_paid / VAL[coin]);
        check({tag, "_change_total"}, d_total, m_sent_total);
        check({tag, "_change_count"}, d_count, (m_sent_n > 255) ? 255 : m_sent_n);
        check({tag, "_no_change"}, d_nc, m_nc);
        check({tag, "_product_ok"}, d_pok, bad ? 0 : 1);
        check({tag, "_error"}, d_err, 0);
    endtask

    initial begin
        int n, p, cn;
        bit b;
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p, cn;
        bit b;
        vecs[0]  = '{3, 5, 32'hAAAA_AAAA, 1'b0, 100,   0, 0, 0,  1};
        vecs[1]  = '{0, 4, 32'hAAAA_AAAA, 1'b0, 150,   0, 0, 0,  3};
        vecs[2]  = '{3, 7, 32'hAAAA_AAAA, 1'b0, 500, 400, 2, 0,  1};
        vecs[3]  = '{3, 7, 32'hA003_0000, 1'b0, 500, 150, 3, 1,  1};
        vecs[4]  = '{1, 6, 32'hAAAA_AAAA, 1'b0, 400, 100, 1, 0,  2};
        vecs[5]  = '{2, 3, 32'hAAAA_AAAA, 1'b0, 200,   0, 0, 0,  8};
        vecs[6]  = '{0, 2, 32'hAAAA_AAAA, 1'b0, 150,   0, 0, 0, 15};
        vecs[7]  = '{1, 7, 32'hAAAA_AAAA, 1'b0, 500, 200, 1, 0,  1};
        vecs[8]  = '{2, 7, 32'hAAAA_AAAA, 1'b1, 500, 300, 2, 0,  1};
        vecs[9]  = '{0, 6, 32'hAAAA_AAAA, 1'b0, 200,  50, 1, 0,  1};
        vecs[10] = '{3, 3, 32'h0000_0000, 1'b0, 100,   0, 0, 0,  4};
        vecs[11] = '{0, 7, 32'h0000_0000, 1'b0, 500,   0, 0, 1,  1};

        i_rst_n = 1'b0;
        i_cmd_valid = 1'b0; i_cmd_product = '0; i_cmd_coin = '0;
        mach.i_busy = 1'b0; mach.i_ready_to_receive = 1'b0; mach.i_change = '0;
        mach.i_change_strobe = 1'b0; mach.i_no_change = 1'b0; mach.i_product = '0;
        mach.i_give_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", o_cmd_ready, 1);
        check("reset_done", o_done, 0);
        check("reset_product_strobe", mach.o_product_strobe, 0);
        check("reset_currency_strobe", mach.o_currency_strobe, 0);
        check("reset_paid", o_paid, 0);
        check("reset_error", o_error, 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            set_stock(vecs[i].stock);
            purchase(vecs[i].prod, vecs[i].coin, vecs[i].bad);
            check($sformatf("vec%0d_paid", i), d_paid, vecs[i].e_paid);
            check($sformatf("vec%0d_change_total", i), d_total, vecs[i].e_total);
            check($sformatf("vec%0d_change_count", i), d_count, vecs[i].e_count);
            check($sformatf("vec%0d_no_change", i), d_nc, vecs[i].e_nc);
            check($sformatf("vec%0d_coins", i), m_coins, vecs[i].e_coins);
            check($sformatf("vec%0d_product_ok", i), d_pok, vecs[i].bad ? 0 : 1);
            check($sformatf("vec%0d_error", i), d_err, 0);
        end

        // change_count saturation: 300 one-unit coins, then the machine runs dry.
        for (int k = 0; k < 8; k++) stock_arr[k] = 0;
        stock_arr[0] = 300;
        purchase(3, 7, 1'b0);
        check("sat_change_total", d_total, 300);
        check("sat_change_count", d_count, 255);
        check("sat_no_change", d_nc, 1);

        for (int r = 0; r < 20; r++) begin
            p  = $urandom_range(0, 3);
            cn = $urandom_range(0, 7);
            b  = ($urandom_range(0, 3) == 0);
            set_stock($urandom() & 32'h3333_3333);
            purchase(p, cn, b);
            score($sformatf("rnd%0d", r), p, cn, b);
        end

        // Timeout: machine never becomes ready; a command held valid must be ignored.
        i_cmd_product = 2'd1; i_cmd_coin = 3'd3; i_cmd_valid = 1'b1;
        tick();
        check("to_product_strobe", mach.o_product_strobe, 1);
        i_cmd_product = 2'd2;
        mach.i_busy = 1'b1;
        n = 0;
        do begin
            tick(); n++;
            if (n == 1) check("to_product_strobe_one_cycle", mach.o_product_strobe, 0);
        end while (!o_done && n < 200);
        i_cmd_valid = 1'b0;
        check("to_latency", n, TO);
        check("to_error", o_error, 1);
        check("to_product_strobe_low", mach.o_product_strobe, 0);
        check("to_currency_strobe_low", mach.o_currency_strobe, 0);
        check("to_paid", o_paid, 0);
        check("to_cmd_ignored", mach.o_product_code, 1);
        check("to_cmd_ready", o_cmd_ready, 1);
        mach.i_busy = 1'b0;
        tick();

        // Asynchronous reset while collecting change.
        i_cmd_product = 2'd3; i_cmd_coin = 3'd7; i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        mach.i_busy = 1'b1;
        mach.i_ready_to_receive = 1'b1;
        tick();
        check("rst_coin_strobe", mach.o_currency_strobe, 1);
        mach.i_ready_to_receive = 1'b0;
        tick();
        tick();
        check("rst_collect_level", mach.o_currency_strobe, 1);
        check("rst_busy_before", o_cmd_ready, 0);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("rst_currency_strobe_async", mach.o_currency_strobe, 0);
        check("rst_product_strobe_async", mach.o_product_strobe, 0);
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_paid_clear", o_paid, 0);
        mach.i_busy = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        tick();
        check("rst_cmd_ready_after", o_cmd_ready, 1);
        set_stock(32'hAAAA_AAAA);
        purchase(3, 5, 1'b0);
        check("post_rst_paid", d_paid, 100);
        check("post_rst_change_total", d_total, 0);
        check("post_rst_change_count", d_count, 0);
        check("post_rst_product_ok", d_pok, 1);
        check("post_rst_error", d_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
